// File: rtl/bit_steg_pkg.sv
// Shared definitions for the LSB steganography embedder/extractor pair.
// Both sides take their default frame geometry and sync header from here.
package bit_steg_pkg;

  localparam int         BPS_DEFAULT            = 24;
  localparam int         MESSAGE_LENGTH_DEFAULT = 88;
  localparam logic [7:0] SYNC_WORD_DEFAULT      = 8'hA5;

  typedef enum logic {
    ST_HUNT    = 1'b0,
    ST_COLLECT = 1'b1
  } state_e;

  // Width needed to hold a bit count from 0 up to and including n.
  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/lsb_sync_detector.sv
// Sliding 8-bit header matcher for the extractor's HUNT phase; pulses match on
// the edge whose incoming bit completes SYNC_WORD, overlapping prefixes included.
module lsb_sync_detector
  import bit_steg_pkg::*;
#(
  parameter logic [7:0] SYNC_WORD = SYNC_WORD_DEFAULT
) (
  input  logic in_clk,
  input  logic in_rst,
  input  logic clear,
  input  logic bit_valid,
  input  logic bit_in,
  output logic match
);

  // Seven stored bits plus the live bit form the 8-bit comparison window.
  logic [6:0] window_q, window_d;
  logic [7:0] candidate;

  assign candidate = {window_q, bit_in};
  assign match     = bit_valid && (candidate == SYNC_WORD);

  always_comb begin
    window_d = window_q;
    if (clear || match) begin
      window_d = '0;
    end else if (bit_valid) begin
      window_d = candidate[6:0];
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      window_q <= '0;
    end else begin
      window_q <= window_d;
    end
  end

endmodule

// File: rtl/bit_extractor_seq.sv
// Recovers an LSB-embedded message from a sample stream, MSB first.
// Define BIT_EXTRACTOR_SYNC_EN to hunt for SYNC_WORD before each message.
module bit_extractor_seq
  import bit_steg_pkg::*;
#(
  parameter int         BPS            = BPS_DEFAULT,
  parameter int         MESSAGE_LENGTH = MESSAGE_LENGTH_DEFAULT,
  parameter logic [7:0] SYNC_WORD      = SYNC_WORD_DEFAULT,
  localparam int        CW             = count_width(MESSAGE_LENGTH)
) (
  input  logic                      in_clk,
  input  logic                      in_rst,
  input  logic                      in_enable,
  input  logic [BPS-1:0]            in_frame,
  input  logic                      in_clear,
  output logic [MESSAGE_LENGTH-1:0] out_message,
  output logic                      out_ready,
  output logic [CW-1:0]             out_bit_count,
  output logic                      out_busy
);

  localparam logic [CW-1:0] LAST_IDX = CW'(MESSAGE_LENGTH - 1);

  // The oldest message bit leaves through the concatenation, so only
  // MESSAGE_LENGTH-1 bits need storing.
  logic [MESSAGE_LENGTH-2:0] shift_q, shift_d;
  logic [MESSAGE_LENGTH-1:0] shifted;
  logic [MESSAGE_LENGTH-1:0] message_q, message_d;
  logic [CW-1:0]             count_q, count_d;
  logic                      ready_q, ready_d;
  logic                      collecting;
  logic                      complete;
  logic                      sample_bit;
  logic                      unused_frame;

  assign sample_bit   = in_frame[0];
  assign unused_frame = ^in_frame;
  assign shifted      = {shift_q, sample_bit};
  assign complete     = in_enable && !in_clear && collecting && (count_q == LAST_IDX);

`ifdef BIT_EXTRACTOR_SYNC_EN
  state_e state_q, state_d;
  logic   hunt_seen_q, hunt_seen_d;
  logic   hunt_valid;
  logic   sync_match;

  assign collecting = (state_q == ST_COLLECT);
  assign hunt_valid = in_enable && !in_clear && (state_q == ST_HUNT);

  lsb_sync_detector #(
    .SYNC_WORD (SYNC_WORD)
  ) u_sync (
    .in_clk    (in_clk),
    .in_rst    (in_rst),
    .clear     (in_clear),
    .bit_valid (hunt_valid),
    .bit_in    (sample_bit),
    .match     (sync_match)
  );

  always_comb begin
    state_d     = state_q;
    hunt_seen_d = hunt_seen_q;
    if (in_clear) begin
      state_d     = ST_HUNT;
      hunt_seen_d = 1'b0;
    end else if (hunt_valid) begin
      hunt_seen_d = !sync_match;
      if (sync_match) state_d = ST_COLLECT;
    end else if (complete) begin
      state_d = ST_HUNT;
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q     <= ST_HUNT;
      hunt_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hunt_seen_q <= hunt_seen_d;
    end
  end

  assign out_busy = (count_q != '0) || ((state_q == ST_HUNT) && hunt_seen_q);
`else
  localparam logic unused_sync_word = ^SYNC_WORD;

  assign collecting = 1'b1;
  assign out_busy   = (count_q != '0);
`endif

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path
    // through this block can infer a latch.
    shift_d   = shift_q;
    count_d   = count_q;
    message_d = message_q;
    ready_d   = 1'b0;
    if (in_clear) begin
      shift_d = '0;
      count_d = '0;
    end else if (in_enable && collecting) begin
      shift_d = shifted[MESSAGE_LENGTH-2:0];
      if (complete) begin
        message_d = shifted;
        ready_d   = 1'b1;
        count_d   = '0;
      end else begin
        count_d = count_q + CW'(1);
      end
    end
  end

  always_ff @(posedge in_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of statement order.
    if (in_rst) begin
      shift_q   <= '0;
      count_q   <= '0;
      message_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      count_q   <= count_d;
      message_q <= message_d;
      ready_q   <= ready_d;
    end
  end

  assign out_message   = message_q;
  assign out_ready     = ready_q;
  assign out_bit_count = count_q;

endmodule

// File: tb/tb_bit_extractor_seq.sv
// Directed bench for bit_extractor_seq: inputs change and outputs are sampled
// on the falling edge, away from the capturing rising edge.
module tb_bit_extractor_seq;

  localparam int BPS = 24;
  localparam int ML  = 88;
  localparam int CW  = 7;

  localparam logic [ML-1:0] HELLO = 88'h48454C4C4F20574F524C44;
  localparam logic [ML-1:0] ONE   = 88'h1;
  localparam logic [ML-1:0] ONES  = {ML{1'b1}};
  localparam logic [ML-1:0] MSG_C = 88'hA5C0FFEE0BADF00D5EED17;

  logic           in_clk = 1'b0;
  logic           in_rst;
  logic           in_enable;
  logic           in_clear;
  logic [BPS-1:0] in_frame;
  logic [ML-1:0]  out_message;
  logic           out_ready;
  logic [CW-1:0]  out_bit_count;
  logic           out_busy;

  int errors = 0;
  int checks = 0;

  bit_extractor_seq dut (
    .in_clk        (in_clk),
    .in_rst        (in_rst),
    .in_enable     (in_enable),
    .in_frame      (in_frame),
    .in_clear      (in_clear),
    .out_message   (out_message),
    .out_ready     (out_ready),
    .out_bit_count (out_bit_count),
    .out_busy      (out_busy)
  );

  always #5 in_clk = ~in_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [ML-1:0] obs, input logic [ML-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs with random upper sample bits, then wait for the
  // falling edge after the rising edge that consumes them.
  task automatic step(input logic en, input logic b, input logic clr);
    logic [BPS-1:0] f;
    f         = BPS'($urandom);
    f[0]      = b;
    in_enable = en;
    in_frame  = f;
    in_clear  = clr;
    @(negedge in_clk);
  endtask

  // Sends m MSB first with gap idle cycles after every sample; prev is the
  // message expected on out_message until the last bit is captured.
  task automatic send_msg(input logic [ML-1:0] m, input int gap,
                          input logic [ML-1:0] prev, input string tag);
    for (int i = ML - 1; i >= 0; i--) begin
      step(1'b1, m[i], 1'b0);
      check({tag, ".ready"}, out_ready, (i == 0));
      check({tag, ".count"}, out_bit_count, (i == 0) ? 0 : ML - i);
      if (i != 0) check({tag, ".hold"}, out_message, prev);
      for (int g = 0; g < gap; g++) begin
        step(1'b0, 1'b0, 1'b0);
        check({tag, ".gap_ready"}, out_ready, 1'b0);
        check({tag, ".gap_msg"}, out_message, (i == 0) ? m : prev);
      end
    end
    check({tag, ".message"}, out_message, m);
  endtask

  initial begin
    in_rst    = 1'b1;
    in_enable = 1'b0;
    in_clear  = 1'b0;
    in_frame  = '0;
    repeat (2) @(negedge in_clk);
    in_rst = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    check("rst.message", out_message, '0);
    check("rst.ready", out_ready, 1'b0);
    check("rst.count", out_bit_count, 0);
    check("rst.busy", out_busy, 1'b0);

`ifndef BIT_EXTRACTOR_SYNC_EN
    send_msg(HELLO, 0, '0, "t1");
    step(1'b0, 1'b0, 1'b0);
    check("t1.idle_ready", out_ready, 1'b0);
    check("t1.idle_busy", out_busy, 1'b0);
    check("t1.idle_msg", out_message, HELLO);

    send_msg(HELLO, 2, HELLO, "t2");

    send_msg(ONE, 0, HELLO, "t3a");
    send_msg(ONES, 0, ONE, "t3b");
    step(1'b0, 1'b0, 1'b0);
    check("t3.idle_ready", out_ready, 1'b0);

    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b0);
    check("t4.count40", out_bit_count, 40);
    check("t4.busy40", out_busy, 1'b1);
    in_rst = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    in_rst = 1'b0;
    check("t4.rst_msg", out_message, '0);
    check("t4.rst_ready", out_ready, 1'b0);
    check("t4.rst_count", out_bit_count, 0);
    check("t4.rst_busy", out_busy, 1'b0);
    send_msg(HELLO, 0, '0, "t4");

    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b0);
    check("t5.count40", out_bit_count, 40);
    step(1'b1, 1'b1, 1'b1);
    check("t5.clr_count", out_bit_count, 0);
    check("t5.clr_msg", out_message, HELLO);
    check("t5.clr_ready", out_ready, 1'b0);
    check("t5.clr_busy", out_busy, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check("t5.idle_count", out_bit_count, 0);
    send_msg(MSG_C, 0, HELLO, "t5");
`else
    begin
      logic [10:0] hdr;
      hdr = {3'b110, 8'hA5};
      for (int i = 10; i >= 0; i--) begin
        step(1'b1, hdr[i], 1'b0);
        check("s1.hdr_ready", out_ready, 1'b0);
        check("s1.hdr_count", out_bit_count, 0);
        if (i == 10) check("s1.hunt_busy", out_busy, 1'b1);
      end
      check("s1.synced_busy", out_busy, 1'b0);
      send_msg(HELLO, 0, '0, "s1");
      hdr = {3'b000, 8'h0F};
      for (int i = 10; i >= 0; i--) begin
        step(1'b1, hdr[i], 1'b0);
        check("s2.ready", out_ready, 1'b0);
        check("s2.count", out_bit_count, 0);
      end
      check("s2.busy", out_busy, 1'b1);
      check("s2.msg", out_message, HELLO);
      step(1'b1, 1'b1, 1'b1);
      check("s3.clr_busy", out_busy, 1'b0);
      check("s3.clr_count", out_bit_count, 0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
